// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: lookup and miss-refill controller for a 2-way, 8-line-per-way data cache.
// Ports: clk/reset; req_valid/req_addr/req_ready request side; resp_valid/resp_data response;
// lineIndex/hit/setNo to and from the FIFO replacement unit; mem_req_valid/mem_req_addr/mem_req_ready
// line-fetch request; mem_rdata_valid/mem_rdata refill beats (offset 0 first).
// Optional macro CACHE_PERF_CNT_EN adds saturating hit_count/miss_count outputs.
// State advances on the falling clock edge so it lines up with the replacement unit.
module cache_refill_ctrl #(
  parameter int TAG_W = 8,
  parameter int DATA_W = 32,
  parameter int WORDS = 4,
  localparam int OFF_W = $clog2(WORDS),
  localparam int AW = TAG_W + 3 + OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [AW-1:0]     req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [2:0]        lineIndex,
  output logic              hit,
  input  logic              setNo,
  output logic              mem_req_valid,
  output logic [TAG_W+2:0]  mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rdata_valid,
`ifdef CACHE_PERF_CNT_EN
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, MISS_REQ = 3'd2, REFILL = 3'd3, RESPOND = 3'd4;
  logic [2:0]        r_state;
  logic [TAG_W-1:0]  r_tag;
  logic [2:0]        r_idx;
  logic [OFF_W-1:0]  r_off;
  logic [OFF_W-1:0]  r_beat;
  logic              r_way;
  logic [15:0]       r_valid;
  logic [DATA_W-1:0] r_resp;
  logic [TAG_W-1:0]  r_tags [2][8];
  logic [DATA_W-1:0] r_data [2][8][WORDS];
  logic              w_m0, w_m1, w_last, w_beat;
  assign w_m0 = r_valid[{1'b0, r_idx}] && r_tags[0][r_idx] == r_tag;
  assign w_m1 = r_valid[{1'b1, r_idx}] && r_tags[1][r_idx] == r_tag;
  assign w_beat = !reset && r_state == REFILL && mem_rdata_valid;
  assign w_last = r_beat == OFF_W'(WORDS - 1);
  assign req_ready = !reset && r_state == IDLE;
  assign resp_valid = !reset && r_state == RESPOND;
  assign resp_data = reset ? '0 : r_resp;
  assign mem_req_valid = !reset && r_state == MISS_REQ;
  assign mem_req_addr = mem_req_valid ? {r_tag, r_idx} : '0;
  assign lineIndex = (reset || r_state == IDLE) ? 3'd0 : r_idx;
  // The single low pulse of hit is what commits the replacement on this line.
  assign hit = !(w_beat && w_last);
  always_ff @(negedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_beat <= '0;
      r_tag <= '0;
      r_idx <= '0;
      r_off <= '0;
      r_way <= 1'b0;
      r_resp <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          {r_tag, r_idx, r_off} <= req_addr;
          r_state <= LOOKUP;
        end
        LOOKUP: if (w_m0 || w_m1) begin
          r_resp <= r_data[w_m1][r_idx][r_off];
          r_state <= RESPOND;
        end else begin
          r_way <= setNo;
          r_state <= MISS_REQ;
        end
        MISS_REQ: r_state <= mem_req_ready ? REFILL : MISS_REQ;
        REFILL: if (mem_rdata_valid) begin
          r_beat <= r_beat + 1'b1;
          if (r_beat == r_off) r_resp <= mem_rdata;
          if (w_last) begin
            r_valid[{r_way, r_idx}] <= 1'b1;
            r_beat <= '0;
            r_state <= RESPOND;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // Arrays carry no reset; the valid bits alone decide whether their contents count.
  always_ff @(negedge clk) begin
    if (w_beat) begin
      r_data[r_way][r_idx][r_beat] <= mem_rdata;
      if (w_last) r_tags[r_way][r_idx] <= r_tag;
    end
  end
`ifdef CACHE_PERF_CNT_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;
  logic        w_lookup;
  assign w_lookup = r_state == LOOKUP;
  assign hit_count = r_hit_cnt;
  assign miss_count = r_miss_cnt;
  always_ff @(negedge clk) begin
    if (reset) begin
      r_hit_cnt <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_hit_cnt <= r_hit_cnt + 16'(w_lookup && (w_m0 || w_m1) && r_hit_cnt != 16'hFFFF);
      r_miss_cnt <= r_miss_cnt + 16'(w_lookup && !(w_m0 || w_m1) && r_miss_cnt != 16'hFFFF);
    end
  end
`endif
endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Lookup and miss-handling controller for the 2-way, 8-line-per-way data cache.
- Sits upstream of the FIFO replacement unit: drives its lineIndex/hit inputs and consumes its setNo victim-way output.
- Holds the tag, valid and data arrays; answers hits from them; on a miss fetches a 4-word line from memory into the victim way, then returns the requested word.

Parameters:
TAG_W, 8, tag bits per address.
DATA_W, 32, word width.
WORDS, 4, words per line, power of 2; offset width OFF_W = log2(WORDS).

Ports:
clk  in  1  single clock; all state updates on the falling edge of clk, matching the replacement unit.
reset  in  1  synchronous, active-high.
req_valid  in  1  read request.
req_addr  in  TAG_W+3+OFF_W  {tag, index[2:0], offset}.
req_ready  out  1  request accepted at an edge where req_valid && req_ready.
resp_valid  out  1  one-cycle pulse with response.
resp_data  out  DATA_W  requested word.
lineIndex  out  3  to replacement unit.
hit  out  1  to replacement unit; 0 commits a replacement on that line.
setNo  in  1  victim way from replacement unit.
mem_req_valid  out  1  line fetch request.
mem_req_addr  out  TAG_W+3  {tag, index}.
mem_req_ready  in  1  memory accepts the fetch.
mem_rdata_valid  in  1  refill beat valid.
mem_rdata  in  DATA_W  refill beat, offset 0 first.

Behaviour:
- Reset (synchronous): state IDLE; all 16 valid bits cleared; beat counter 0.
- Output values under reset: req_ready=0, resp_valid=0, resp_data=0, mem_req_valid=0, mem_req_addr=0, lineIndex=0, hit=1.
- Reset overrides any state, including mid-refill; beats already written stay invalid; stray mem_rdata_valid after reset is ignored.
- IDLE:
  - req_ready=1.
  - On accept, latch tag/index/offset and go to LOOKUP.
- LOOKUP (1 cycle):
  - lineIndex=index; hit held 1.
  - Compare tag against both ways; a way matches only if its valid bit is set.
  - Match: latch word into resp_data, go to RESPOND.
  - No match: latch setNo as victim_way, go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1 and mem_req_addr={tag,index}, both stable until the edge where mem_req_ready=1; then go to REFILL.
- REFILL:
  - Each edge with mem_rdata_valid=1 writes mem_rdata to data[victim_way][index][beat] and increments beat.
  - When beat==offset, the beat is also copied to resp_data.
  - On the last beat (beat==WORDS-1): write tag, set valid, drive hit=0 for that cycle only, reset beat, go to RESPOND.
  - Gaps (mem_rdata_valid=0) are allowed and hold state.
- RESPOND (1 cycle): resp_valid=1, then go to IDLE.
- Replacement handshake:
  - hit is 0 for exactly one clock edge per miss and 1 at every other edge, including hits, idle, stalls and reset.
  - lineIndex is held at the request index from LOOKUP through RESPOND.
  - The victim way is always setNo; invalid ways are not preferred, so the FIFO order stays consistent.
- Latency:
  - Hit: resp_valid in the cycle after the second edge following accept (accept edge, LOOKUP edge).
  - Miss: the last-beat edge plus 1.
  - req_ready=0 from accept until back in IDLE; no second request is ever in flight.
- resp_data holds its value until the next response.

Optional Feature:
- Macro CACHE_PERF_CNT_EN.
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments at the LOOKUP edge according to the result.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. After reset, read tag 0x12, index 3, offset 1 with setNo=0 -> miss; mem_req_addr={0x12,3}; beats 0xA0..0xA3 -> resp_data=0xA1, resp_valid one cycle; hit low at exactly one edge, lineIndex=3.
2. Re-read 0x12/3/offset 2 -> resp_data=0xA2 two edges after accept; mem_req_valid stays 0; hit stays 1.
3. Miss tag 0x34 index 3 with setNo=1, then miss tag 0x56 index 3 with setNo=0 -> way0 evicted; reading 0x34 hits; reading 0x12 misses.
4. Hold mem_req_ready=0 for 5 cycles during a miss -> mem_req_valid and mem_req_addr stable; req_ready=0; no resp_valid.
5. Assert reset after 2 refill beats, then send 2 more beats -> returns to IDLE, beats ignored; re-reading the same address misses again; hit stays 1 throughout.
6. With CACHE_PERF_CNT_EN, run 2 misses then 3 hits -> miss_count=2, hit_count=3; after reset both are 0.
